// File: rtl/getir_coz_tamponu.sv
// ---------------------------------------------------------------------------
// getir_coz_tamponu
// Fetch-to-decode instruction buffer. A small circular FIFO that holds
// {PC, instruction, predicted-taken} entries between the fetch and the
// decode stages, with a single-cycle flush for pipeline redirects.
//
// Parameters
//   DERINLIK        entry count, power of two in 2..16
//
// Ports
//   clk_i           single clock, all state changes on its rising edge
//   rst_i           synchronous active-high reset
//   getir_gecerli_i fetch side: entry valid
//   getir_ps_i      fetch side: PC
//   getir_buyruk_i  fetch side: instruction word
//   getir_ongoru_i  fetch side: predicted-taken
//   getir_hazir_o   buffer accepts an entry this cycle
//   coz_gecerli_o   decode side: head entry valid
//   coz_ps_o        decode side: head PC (0 when not valid)
//   coz_buyruk_o    decode side: head instruction (NOP when not valid)
//   coz_ongoru_o    decode side: head predicted-taken (0 when not valid)
//   coz_hazir_i     decode accepts the head this cycle
//   temizle_i       flush: discard every stored entry at the next edge
//   doluluk_o       occupancy
//   bos_o           buffer empty
//   dolu_o          buffer full
//
// Build option
//   GETIR_COZ_ATLAMA_EN  adds a zero-latency bypass: with an empty buffer
//                        the fetch entry is presented to decode in the
//                        same cycle.
// ---------------------------------------------------------------------------
module getir_coz_tamponu #(
    parameter int DERINLIK = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        getir_gecerli_i,
    input  logic [31:0]                 getir_ps_i,
    input  logic [31:0]                 getir_buyruk_i,
    input  logic                        getir_ongoru_i,
    output logic                        getir_hazir_o,

    output logic                        coz_gecerli_o,
    output logic [31:0]                 coz_ps_o,
    output logic [31:0]                 coz_buyruk_o,
    output logic                        coz_ongoru_o,
    input  logic                        coz_hazir_i,

    input  logic                        temizle_i,

    output logic [$clog2(DERINLIK):0]   doluluk_o,
    output logic                        bos_o,
    output logic                        dolu_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] TAM = CW'(DERINLIK);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Storage: payload only, never reset.
    logic [31:0] ps_mem     [DERINLIK];
    logic [31:0] buyruk_mem [DERINLIK];
    logic        ongoru_mem [DERINLIK];

    logic [AW-1:0] yaz_ptr;
    logic [AW-1:0] oku_ptr;
    logic [CW-1:0] doluluk;

    logic itme;
    logic cekme;
    logic atlama;

    // Status flags derive from registered occupancy only, so getir_hazir_o
    // has no combinational dependence on the decode side.
    assign bos_o         = (doluluk == '0);
    assign dolu_o        = (doluluk == TAM);
    assign doluluk_o     = doluluk;
    assign getir_hazir_o = (doluluk < TAM) && !rst_i;

`ifdef GETIR_COZ_ATLAMA_EN
    assign atlama = bos_o && getir_gecerli_i && !temizle_i;
`else
    assign atlama = 1'b0;
`endif

    assign coz_gecerli_o = (!bos_o && !temizle_i) || atlama;

    always_comb begin
        coz_ps_o     = 32'h0;
        coz_buyruk_o = NOP;
        coz_ongoru_o = 1'b0;
        if (atlama) begin
            coz_ps_o     = getir_ps_i;
            coz_buyruk_o = getir_buyruk_i;
            coz_ongoru_o = getir_ongoru_i;
        end else if (coz_gecerli_o) begin
            coz_ps_o     = ps_mem[oku_ptr];
            coz_buyruk_o = buyruk_mem[oku_ptr];
            coz_ongoru_o = ongoru_mem[oku_ptr];
        end
    end

    assign itme  = getir_gecerli_i && getir_hazir_o && !temizle_i;
    assign cekme = coz_gecerli_o && coz_hazir_i && !temizle_i;

    // A bypassed-and-consumed entry is a simultaneous push and pop on an
    // empty buffer: both pointers step together and occupancy stays 0,
    // so the written slot is immediately behind the read pointer and dead.
    always_ff @(posedge clk_i) begin
        if (itme) begin
            ps_mem[yaz_ptr]     <= getir_ps_i;
            buyruk_mem[yaz_ptr] <= getir_buyruk_i;
            ongoru_mem[yaz_ptr] <= getir_ongoru_i;
        end
    end

    // Pointers wrap naturally because DERINLIK is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || temizle_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else begin
            if (itme)
                yaz_ptr <= yaz_ptr + AW'(1);
            if (cekme)
                oku_ptr <= oku_ptr + AW'(1);
            case ({itme, cekme})
                2'b10:   doluluk <= doluluk + CW'(1);
                2'b01:   doluluk <= doluluk - CW'(1);
                default: doluluk <= doluluk;
            endcase
        end
    end

endmodule

// File: tb/tb_getir_coz_tamponu.sv
module tb_getir_coz_tamponu;

    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
`ifdef GETIR_COZ_ATLAMA_EN
    localparam bit ATL = 1'b1;
`else
    localparam bit ATL = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        getir_gecerli_i = 1'b0;
    logic [31:0] getir_ps_i = '0;
    logic [31:0] getir_buyruk_i = '0;
    logic        getir_ongoru_i = 1'b0;
    logic        getir_hazir_o;
    logic        coz_gecerli_o;
    logic [31:0] coz_ps_o;
    logic [31:0] coz_buyruk_o;
    logic        coz_ongoru_o;
    logic        coz_hazir_i = 1'b0;
    logic        temizle_i = 1'b0;
    logic [CW-1:0] doluluk_o;
    logic        bos_o;
    logic        dolu_o;

    getir_coz_tamponu #(.DERINLIK(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .getir_gecerli_i(getir_gecerli_i), .getir_ps_i(getir_ps_i),
        .getir_buyruk_i(getir_buyruk_i), .getir_ongoru_i(getir_ongoru_i),
        .getir_hazir_o(getir_hazir_o),
        .coz_gecerli_o(coz_gecerli_o), .coz_ps_o(coz_ps_o),
        .coz_buyruk_o(coz_buyruk_o), .coz_ongoru_o(coz_ongoru_o),
        .coz_hazir_i(coz_hazir_i), .temizle_i(temizle_i),
        .doluluk_o(doluluk_o), .bos_o(bos_o), .dolu_o(dolu_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ps;
        logic [31:0] buyruk;
        logic        ongoru;
    } giris_t;

    giris_t kuyruk[$];
    int toplam = 0;
    int hata   = 0;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hata++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h t=%0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check combinational view,
    // advance the reference queue, then cross the rising edge.
    task automatic adim(input bit g, input logic [31:0] p, input logic [31:0] b,
                        input bit o, input bit h, input bit t, input bit r);
        giris_t yeni;
        giris_t bas;
        bit     hazir_b, gec_b, itme_b, cekme_b;
        int     n;
        getir_gecerli_i = g;
        getir_ps_i      = p;
        getir_buyruk_i  = b;
        getir_ongoru_i  = o;
        coz_hazir_i     = h;
        temizle_i       = t;
        rst_i           = r;
        #1;
        yeni.ps = p; yeni.buyruk = b; yeni.ongoru = o;
        n       = kuyruk.size();
        hazir_b = !r && (n < D);
        gec_b   = !t && ((n > 0) || (ATL && g));
        if (!gec_b) begin
            bas.ps = 32'h0; bas.buyruk = 32'h13; bas.ongoru = 1'b0;
        end else if (n > 0) begin
            bas = kuyruk[0];
        end else begin
            bas = yeni;
        end
        kontrol("getir_hazir", 64'(getir_hazir_o), 64'(hazir_b));
        kontrol("coz_gecerli", 64'(coz_gecerli_o), 64'(gec_b));
        kontrol("coz_ps",      64'(coz_ps_o),      64'(bas.ps));
        kontrol("coz_buyruk",  64'(coz_buyruk_o),  64'(bas.buyruk));
        kontrol("coz_ongoru",  64'(coz_ongoru_o),  64'(bas.ongoru));
        kontrol("doluluk",     64'(doluluk_o),     64'(n));
        kontrol("bos",         64'(bos_o),         64'(n == 0));
        kontrol("dolu",        64'(dolu_o),        64'(n == D));
        if (r || t) begin
            kuyruk.delete();
        end else begin
            itme_b  = g && hazir_b;
            cekme_b = gec_b && h;
            if (n == 0) begin
                if (itme_b && !cekme_b) kuyruk.push_back(yeni);
            end else begin
                if (cekme_b) void'(kuyruk.pop_front());
                if (itme_b)  kuyruk.push_back(yeni);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic bos_adim();
        adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic it(input logic [31:0] p);
        adim(1'b1, p, p ^ 32'hA5A5_0000, p[2], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        // initial reset: storage and state are unknown before the first edge
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        kontrol("sifir_doluluk", 64'(doluluk_o), 64'd0);
        kontrol("sifir_bos",     64'(bos_o), 64'd1);
        kontrol("sifir_dolu",    64'(dolu_o), 64'd0);
        kontrol("sifir_gecerli", 64'(coz_gecerli_o), 64'd0);
        kontrol("sifir_buyruk",  64'(coz_buyruk_o), 64'h13);
        kontrol("sifir_hazir",   64'(getir_hazir_o), 64'd1);
        @(negedge clk_i);

        // fill
        it(32'h100); it(32'h104); it(32'h108); it(32'h10C);
        adim(1'b1, 32'h110, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); // refused, full
        kontrol("dolu_doluluk", 64'(doluluk_o), 64'd4);
        kontrol("dolu_bayrak",  64'(dolu_o), 64'd1);
        kontrol("dolu_hazir",   64'(getir_hazir_o), 64'd0);
        kontrol("dolu_bas_ps",  64'(coz_ps_o), 64'h100);

        // drain in order
        for (int i = 0; i < 4; i++) begin
            getir_gecerli_i = 1'b0; coz_hazir_i = 1'b1; #1;
            kontrol("bosalt_ps", 64'(coz_ps_o), 64'(32'h100 + 4 * i));
            #0;
            adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        kontrol("bosalt_bos", 64'(bos_o), 64'd1);
        kontrol("bosalt_nop", 64'(coz_buyruk_o), 64'h13);

        // streaming at occupancy 2
        it(32'h400); it(32'h404);
        pc = 32'h408;
        for (int i = 0; i < 20; i++) begin
            adim(1'b1, pc, ~pc, pc[3], 1'b1, 1'b0, 1'b0);
            kontrol("akis_doluluk", 64'(doluluk_o), 64'd2);
            pc += 4;
        end
        bos_adim();
        adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // flush with a concurrent push
        it(32'h500); it(32'h504); it(32'h508);
        adim(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        kontrol("temizle_doluluk", 64'(doluluk_o), 64'd0);
        for (int i = 0; i < 3; i++) adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // bypass / one-cycle latency from empty
        adim(1'b1, 32'h300, 32'h0000_0093, 1'b1, 1'b1, 1'b0, 1'b0);
        kontrol("atlama_doluluk", 64'(doluluk_o), ATL ? 64'd0 : 64'd1);
        adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        adim(1'b1, 32'h304, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        kontrol("atlama_sakla", 64'(doluluk_o), 64'd1);
        adim(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset mid-run
        it(32'h600); it(32'h604);
        adim(1'b1, 32'h608, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst_i = 1'b0; getir_gecerli_i = 1'b0; #1;
        kontrol("reset_doluluk", 64'(doluluk_o), 64'd0);
        kontrol("reset_hazir",   64'(getir_hazir_o), 64'd1);
        bos_adim();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            adim($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata);
        $finish;
    end

endmodule

// File: doc/getir_coz_tamponu.md
GETIR_COZ_TAMPONU -- requirements
Module: getir_coz_tamponu

Interface
REQ-001 The block SHALL have parameter DERINLIK, default 4, entry count; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports getir_gecerli_i input 1, getir_ps_i input 32, getir_buyruk_i input 32, getir_ongoru_i input 1: the fetch-side entry (valid, PC, instruction, predicted-taken).
REQ-005 The block SHALL have port getir_hazir_o, output, 1, buffer can accept an entry this cycle.
REQ-006 The block SHALL have ports coz_gecerli_o output 1, coz_ps_o output 32, coz_buyruk_o output 32, coz_ongoru_o output 1: the head entry to decode.
REQ-007 The block SHALL have port coz_hazir_i, input, 1, decode accepts the head this cycle.
REQ-008 The block SHALL have port temizle_i, input, 1, flush (branch mispredict / jal / mret redirect).
REQ-009 The block SHALL have ports doluluk_o output $clog2(DERINLIK)+1 (occupancy), bos_o output 1 (empty), dolu_o output 1 (full).

Function
REQ-010 Push SHALL occur when getir_gecerli_i && getir_hazir_o && !temizle_i; the entry is written at the write pointer.
REQ-011 Pop SHALL occur when coz_gecerli_o && coz_hazir_i && !temizle_i; the read pointer advances.
REQ-012 getir_hazir_o SHALL be 1 iff doluluk_o < DERINLIK and rst_i is 0; it SHALL NOT depend combinationally on coz_hazir_i (a full buffer refuses a push even if a pop happens in the same cycle).
REQ-013 Read and write pointers SHALL wrap modulo DERINLIK.
REQ-014 Occupancy SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-015 bos_o SHALL be (doluluk_o == 0); dolu_o SHALL be (doluluk_o == DERINLIK).
REQ-016 coz_gecerli_o SHALL be !bos_o && !temizle_i; the head payload SHALL be driven from storage, so push-to-visible latency is 1 cycle.
REQ-017 When coz_gecerli_o is 0, coz_ps_o SHALL be 32'h0, coz_buyruk_o 32'h00000013 (NOP), and coz_ongoru_o 0.
REQ-018 Entries SHALL leave in push order; the payload {ps, buyruk, ongoru} is never altered.
REQ-019 temizle_i=1 in cycle N SHALL discard all entries at the edge ending N: pointers 0, doluluk_o 0, and any push or pop in cycle N ignored; getir_hazir_o is 1 in N+1.
REQ-020 temizle_i SHALL take priority over push, pop and bypass in the same cycle.
REQ-021 A push into a full buffer and a pop from an empty buffer SHALL be impossible by construction (gated by REQ-012/REQ-016); occupancy never exceeds DERINLIK or underflows.

Reset
REQ-022 On rst_i=1 at a clock edge: pointers 0, doluluk_o 0, bos_o 1, dolu_o 0, coz_gecerli_o 0, with payload outputs per REQ-017.
REQ-023 getir_hazir_o SHALL be 0 while rst_i=1; reset mid-operation SHALL discard stored entries exactly like a flush.
REQ-024 Storage array contents SHALL NOT require reset; only pointers and occupancy are reset.

Configuration
REQ-025 Macro GETIR_COZ_ATLAMA_EN SHALL compile in a zero-latency bypass.
REQ-026 With GETIR_COZ_ATLAMA_EN: when bos_o=1, getir_gecerli_i=1 and temizle_i=0, coz_gecerli_o SHALL be 1 and coz_* SHALL equal getir_* combinationally; if coz_hazir_i=1 the entry is consumed and not stored, otherwise it is stored (occupancy becomes 1).
REQ-027 Without GETIR_COZ_ATLAMA_EN: no combinational path from getir_* to coz_*; the empty-buffer latency is 1 cycle.

Verification
REQ-028 Fill: after reset, coz_hazir_i=0, push PCs 0x100,0x104,0x108,0x10C -> doluluk_o=4, dolu_o=1, getir_hazir_o=0, coz_ps_o=0x100.
REQ-029 Drain order: then coz_hazir_i=1 for 4 cycles -> coz_ps_o 0x100,0x104,0x108,0x10C in consecutive cycles, then bos_o=1, coz_buyruk_o=0x00000013.
REQ-030 Streaming: continuous push and pop at occupancy 2 for 20 cycles -> doluluk_o stays 2, pointers wrap, no loss or reorder.
REQ-031 Flush: occupancy 3, temizle_i=1 together with a push of 0x200 -> next cycle doluluk_o=0, coz_gecerli_o=0, 0x200 never appears.
REQ-032 Bypass (macro on): empty buffer, push 0x300 with coz_hazir_i=1 -> coz_ps_o=0x300 the same cycle, doluluk_o stays 0; with macro off -> 0x300 appears one cycle later.
REQ-033 Reset mid-run: occupancy 2, rst_i=1 for one cycle -> doluluk_o=0, getir_hazir_o=0 during reset and 1 afterward.
